// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - shared addresses, frame size and FSM encoding for the MAX7219 responder model.
package max7219_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  localparam logic [3:0] ADDR_NOOP         = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0       = 4'h1;
  localparam logic [3:0] ADDR_DIGIT7       = 4'h8;
  localparam logic [3:0] ADDR_DECODE       = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY    = 4'hA;
  localparam logic [3:0] ADDR_SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN     = 4'hC;
  localparam logic [3:0] ADDR_DISPLAY_TEST = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

endpackage

// File: rtl/max7219_code_b_decoder.sv
// rtl/max7219_code_b_decoder.sv - Code-B font: 4-bit nibble plus DP to {DP,A,B,C,D,E,F,G} segments.
module max7219_code_b_decoder (
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  output logic [7:0] o_segments
);

  logic [6:0] seg;

  always_comb begin
    seg = 7'h00;
    case (i_nibble)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h01; // '-'
      4'hB: seg = 7'h4F; // 'E'
      4'hC: seg = 7'h37; // 'H'
      4'hD: seg = 7'h0E; // 'L'
      4'hE: seg = 7'h67; // 'P'
      default: seg = 7'h00;
    endcase
    o_segments = {i_dp, seg};
  end

endmodule

// File: rtl/max7219_spi_receiver.sv
// rtl/max7219_spi_receiver.sv - MAX7219 write-path responder: SPI deserializer, register file, readback.
// Define MAX7219_DECODE_EN to apply Code-B decoding on readback for digits selected by decode mode.
module max7219_spi_receiver
  import max7219_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_spi_clk,
  input  logic       i_spi_din,
  input  logic       i_spi_load,
  output logic       o_spi_dout,
  output logic       o_stb,
  output logic [3:0] o_addr,
  output logic [7:0] o_data,
  output logic       o_frame_err,
  input  logic [2:0] i_rd_digit,
  output logic [7:0] o_rd_segment,
  output logic [7:0] o_decode_mode,
  output logic [3:0] o_intensity,
  output logic [2:0] o_scan_limit,
  output logic       o_enable,
  output logic       o_display_test
);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   load_prev_q, load_prev_d;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic                   dout_q, dout_d;
  logic                   stb_q, stb_d;
  logic                   err_q, err_d;
  logic [3:0]             addr_q, addr_d;
  logic [7:0]             data_q, data_d;

  logic [7:0]             digit_q [8];
  logic [7:0]             digit_d [8];
  logic [7:0]             decode_q, decode_d;
  logic [3:0]             intensity_q, intensity_d;
  logic [2:0]             scan_q, scan_d;
  logic                   enable_q, enable_d;
  logic                   test_q, test_d;

  logic spi_clk_s, spi_din_s, spi_load_s;
  logic clk_rise, clk_fall, load_rise, load_fall;
  logic [3:0] frame_addr;
  logic [7:0] frame_data;

  assign spi_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign spi_din_s  = din_sync_q[SYNC_STAGES-1];
  assign spi_load_s = load_sync_q[SYNC_STAGES-1];

  assign clk_rise   = spi_clk_s & ~clk_prev_q;
  assign clk_fall   = ~spi_clk_s & clk_prev_q;
  assign load_rise  = spi_load_s & ~load_prev_q;
  assign load_fall  = ~spi_load_s & load_prev_q;

  // Only the last 16 bits shifted in form the frame; the top nibble is don't-care.
  assign frame_addr = shift_q[11:8];
  assign frame_data = shift_q[7:0];

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], i_spi_clk};
    din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], i_spi_din};
    load_sync_d = {load_sync_q[SYNC_STAGES-2:0], i_spi_load};
    clk_prev_d  = spi_clk_s;
    load_prev_d = spi_load_s;

    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    dout_d      = dout_q;
    stb_d       = 1'b0;
    err_d       = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    digit_d     = digit_q;
    decode_d    = decode_q;
    intensity_d = intensity_q;
    scan_d      = scan_q;
    enable_d    = enable_q;
    test_d      = test_q;

    case (state_q)
      ST_IDLE: begin
        if (load_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        // A clock rise seen together with the LOAD rise still contributes its bit.
        if (clk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], spi_din_s};
          if (cnt_q < CNT_W'(FRAME_BITS)) cnt_d = cnt_q + CNT_W'(1);
        end
        if (clk_fall) dout_d = shift_q[FRAME_BITS-1];
        if (load_rise) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        if (load_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
        if (cnt_q == CNT_W'(FRAME_BITS)) begin
          stb_d  = 1'b1;
          addr_d = frame_addr;
          data_d = frame_data;
          if (frame_addr >= ADDR_DIGIT0 && frame_addr <= ADDR_DIGIT7) begin
            digit_d[3'(frame_addr - ADDR_DIGIT0)] = frame_data;
          end else begin
            case (frame_addr)
              ADDR_DECODE:       decode_d    = frame_data;
              ADDR_INTENSITY:    intensity_d = frame_data[3:0];
              ADDR_SCAN_LIMIT:   scan_d      = frame_data[2:0];
              ADDR_SHUTDOWN:     enable_d    = frame_data[0];
              ADDR_DISPLAY_TEST: test_d      = frame_data[0];
              default: ;
            endcase
          end
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      clk_sync_q  <= '0;
      din_sync_q  <= '0;
      load_sync_q <= '0;
      clk_prev_q  <= 1'b0;
      load_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      dout_q      <= 1'b0;
      stb_q       <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      digit_q     <= '{default: '0};
      decode_q    <= '0;
      intensity_q <= '0;
      scan_q      <= '0;
      enable_q    <= 1'b0;
      test_q      <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      din_sync_q  <= din_sync_d;
      load_sync_q <= load_sync_d;
      clk_prev_q  <= clk_prev_d;
      load_prev_q <= load_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      stb_q       <= stb_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      digit_q     <= digit_d;
      decode_q    <= decode_d;
      intensity_q <= intensity_d;
      scan_q      <= scan_d;
      enable_q    <= enable_d;
      test_q      <= test_d;
    end
  end

  assign o_spi_dout     = dout_q;
  assign o_stb          = stb_q;
  assign o_frame_err    = err_q;
  assign o_addr         = addr_q;
  assign o_data         = data_q;
  assign o_decode_mode  = decode_q;
  assign o_intensity    = intensity_q;
  assign o_scan_limit   = scan_q;
  assign o_enable       = enable_q;
  assign o_display_test = test_q;

`ifdef MAX7219_DECODE_EN
  logic [7:0] rd_decoded;

  max7219_code_b_decoder u_code_b (
    .i_nibble   (digit_q[i_rd_digit][3:0]),
    .i_dp       (digit_q[i_rd_digit][7]),
    .o_segments (rd_decoded)
  );

  always_comb begin
    o_rd_segment = digit_q[i_rd_digit];
    if (decode_q[i_rd_digit]) o_rd_segment = rd_decoded;
  end
`else
  assign o_rd_segment = digit_q[i_rd_digit];
`endif

endmodule

// File: tb/tb_max7219_spi_receiver.sv
// tb/tb_max7219_spi_receiver.sv - directed bench for the MAX7219 SPI responder.
module tb_max7219_spi_receiver;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_spi_clk = 1'b0;
  logic       i_spi_din = 1'b0;
  logic       i_spi_load = 1'b1;
  logic [2:0] i_rd_digit = 3'd0;
  logic       o_spi_dout, o_stb, o_frame_err, o_enable, o_display_test;
  logic [3:0] o_addr, o_intensity;
  logic [7:0] o_data, o_rd_segment, o_decode_mode;
  logic [2:0] o_scan_limit;

  int tests = 0;
  int fails = 0;
  int stb_total = 0;
  int err_total = 0;
  int stb_base, err_base;
  logic [19:0] long_word;

`ifdef MAX7219_DECODE_EN
  localparam logic [7:0] DIGIT0_READ = 8'hDB;
`else
  localparam logic [7:0] DIGIT0_READ = 8'h85;
`endif

  max7219_spi_receiver #(.SYNC_STAGES(2)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_spi_clk      (i_spi_clk),
    .i_spi_din      (i_spi_din),
    .i_spi_load     (i_spi_load),
    .o_spi_dout     (o_spi_dout),
    .o_stb          (o_stb),
    .o_addr         (o_addr),
    .o_data         (o_data),
    .o_frame_err    (o_frame_err),
    .i_rd_digit     (i_rd_digit),
    .o_rd_segment   (o_rd_segment),
    .o_decode_mode  (o_decode_mode),
    .o_intensity    (o_intensity),
    .o_scan_limit   (o_scan_limit),
    .o_enable       (o_enable),
    .o_display_test (o_display_test)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_stb) stb_total = stb_total + 1;
    if (o_frame_err) err_total = err_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    stb_base = stb_total;
    err_base = err_total;
  endtask

  task automatic send_frame(input logic [31:0] w, input int n, input bit coincident);
    i_spi_load = 1'b0;
    #60;
    for (int i = n - 1; i >= 0; i--) begin
      i_spi_din = w[i];
      #60;
      i_spi_clk = 1'b1;
      if (coincident && i == 0) i_spi_load = 1'b1;
      #60;
      i_spi_clk = 1'b0;
    end
    if (!coincident) begin
      #60;
      i_spi_load = 1'b1;
    end
    #200;
  endtask

  initial begin
    #30;
    check("reset_stb", o_stb, 0);
    check("reset_addr", o_addr, 0);
    check("reset_intensity", o_intensity, 0);
    check("reset_enable", o_enable, 0);
    check("reset_dout", o_spi_dout, 0);
    check("reset_rd_segment", o_rd_segment, 0);
    #10;
    i_reset_n = 1'b1;
    #100;

    mark();
    send_frame(32'h0A07, 16, 1'b0);
    check("f0a07_stb_count", stb_total - stb_base, 1);
    check("f0a07_addr", o_addr, 4'hA);
    check("f0a07_data", o_data, 8'h07);
    check("f0a07_intensity", o_intensity, 4'h7);
    check("f0a07_no_err", err_total - err_base, 0);

    mark();
    send_frame(32'h037E, 16, 1'b0);
    i_rd_digit = 3'd2;
    #10;
    check("f037e_stb_count", stb_total - stb_base, 1);
    check("f037e_rd_digit2", o_rd_segment, 8'h7E);

    mark();
    send_frame(32'hFFF, 12, 1'b0);
    check("short_err_count", err_total - err_base, 1);
    check("short_no_stb", stb_total - stb_base, 0);
    check("short_addr_held", o_addr, 4'h3);
    check("short_intensity_kept", o_intensity, 4'h7);
    check("short_digit2_kept", o_rd_segment, 8'h7E);

    mark();
    long_word = 20'hA0C01;
    i_spi_load = 1'b0;
    #60;
    for (int i = 0; i < 20; i++) begin
      i_spi_din = long_word[19 - i];
      #60;
      i_spi_clk = 1'b1;
      #60;
      i_spi_clk = 1'b0;
      if (i >= 15) begin
        #50;
        check($sformatf("long_dout_fall%0d", i + 1), o_spi_dout, long_word[19 - (i - 15)]);
      end
    end
    #60;
    i_spi_load = 1'b1;
    #200;
    check("long_stb_count", stb_total - stb_base, 1);
    check("long_addr", o_addr, 4'hC);
    check("long_data", o_data, 8'h01);
    check("long_enable", o_enable, 1);

    send_frame(32'h09FF, 16, 1'b0);
    send_frame(32'h0185, 16, 1'b0);
    i_rd_digit = 3'd0;
    #10;
    check("decode_mode", o_decode_mode, 8'hFF);
    check("digit0_readback", o_rd_segment, DIGIT0_READ);

    mark();
    send_frame(32'h0B05, 16, 1'b1);
    check("coincident_stb_count", stb_total - stb_base, 1);
    check("coincident_scan_limit", o_scan_limit, 3'd5);

    mark();
    send_frame(32'hFD55, 16, 1'b0);
    check("noop_d_stb_count", stb_total - stb_base, 1);
    check("noop_d_addr", o_addr, 4'hD);
    check("noop_d_data", o_data, 8'h55);
    check("noop_d_scan_kept", o_scan_limit, 3'd5);
    check("noop_d_test_kept", o_display_test, 0);
    check("dout_after_fd55", o_spi_dout, 1);

    i_spi_din = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #60;
      i_spi_clk = 1'b1;
      #60;
      i_spi_clk = 1'b0;
    end
    #100;
    check("load_high_dout_hold", o_spi_dout, 1);
    check("load_high_no_stb", stb_total - stb_base, 1);

    mark();
    i_spi_load = 1'b0;
    #60;
    for (int i = 0; i < 8; i++) begin
      i_spi_din = 1'b1;
      #60;
      i_spi_clk = 1'b1;
      #60;
      i_spi_clk = 1'b0;
    end
    #60;
    i_reset_n = 1'b0;
    #30;
    i_reset_n = 1'b1;
    #40;
    i_spi_load = 1'b1;
    #100;
    check("reset_mid_intensity", o_intensity, 0);
    send_frame(32'h0F01, 16, 1'b0);
    i_rd_digit = 3'd2;
    #10;
    check("reset_mid_stb_count", stb_total - stb_base, 1);
    check("reset_mid_err_count", err_total - err_base, 0);
    check("reset_mid_display_test", o_display_test, 1);
    check("reset_mid_addr", o_addr, 4'hF);
    check("reset_mid_digit2_cleared", o_rd_segment, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
